// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - instruction fetch memory with program-load port and fault flags
module instr_fetch_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fault_align,
  output logic              fault_range,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              fetch_mis;
  logic              fetch_oor;
  logic              load_ok;
  logic              accept;
  logic [DATA_W-1:0] rd_data;

  assign fetch_idx = addr[ADDR_W-1:2];
  assign load_idx  = load_addr[ADDR_W-1:2];
  assign fetch_mis = (addr[1:0] != 2'b00);
  assign fetch_oor = ({1'b0, fetch_idx} >= DEPTH_LIM);
  assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && ({1'b0, load_idx} < DEPTH_LIM);
  assign accept    = fetch_req && !stall;

  // Write-first: a same-cycle load to the fetched word is forwarded.
  always_comb begin
    rd_data = mem[fetch_idx[MEM_AW-1:0]];
    if (load_ok && (load_idx == fetch_idx))
      rd_data = load_data;
  end

  always_ff @(posedge clock) begin
    if (!reset && load_ok)
      mem[load_idx[MEM_AW-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      fault_align <= 1'b0;
      fault_range <= 1'b0;
      fetch_count <= '0;
    end else if (accept) begin
      instruction <= (fetch_mis || fetch_oor) ? '0 : rd_data;
      instr_valid <= 1'b1;
      fault_align <= fetch_mis;
      fault_range <= fetch_oor;
      fetch_count <= fetch_count + 1'b1;
    end else if (!stall) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      fault_align <= 1'b0;
      fault_range <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed self-checking bench for instr_fetch_mem
module tb_instr_fetch_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        stall;
  logic [31:0] addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fault_align;
  logic        fault_range;
  logic [3:0]  fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .stall       (stall),
    .addr        (addr),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .fault_align (fault_align),
    .fault_range (fault_range),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic v,
                         input logic fa, input logic fr, input logic [3:0] cnt);
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({tag, ".fault_align"}, {31'b0, fault_align}, {31'b0, fa});
    chk({tag, ".fault_range"}, {31'b0, fault_range}, {31'b0, fr});
    chk({tag, ".fetch_count"}, {28'b0, fetch_count}, {28'b0, cnt});
  endtask

  task automatic step(input logic rst, input logic fr, input logic st, input logic [31:0] a,
                      input logic le, input logic [31:0] la, input logic [31:0] ld);
    reset = rst; fetch_req = fr; stall = st; addr = a;
    load_en = le; load_addr = la; load_data = ld;
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    chk_out("reset", 32'h0, 0, 0, 0, 4'd0);

    step(0, 0, 0, 0, 1, 32'd0, 32'h01098020);
    chk_out("load0", 32'h0, 0, 0, 0, 4'd0);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    chk_out("fetch0", 32'h01098020, 1, 0, 0, 4'd1);

    step(0, 0, 0, 0, 1, 32'd4, 32'hAC0C0004);
    chk_out("load4", 32'h0, 0, 0, 0, 4'd1);
    step(0, 1, 0, 32'd6, 0, 0, 0);
    chk_out("fetch6_mis", 32'h0, 1, 1, 0, 4'd2);
    step(0, 1, 0, 32'd4, 0, 0, 0);
    chk_out("fetch4", 32'hAC0C0004, 1, 0, 0, 4'd3);

    step(0, 1, 0, 32'd256, 0, 0, 0);
    chk_out("fetch256_oor", 32'h0, 1, 0, 1, 4'd4);
    step(0, 1, 0, 32'd258, 0, 0, 0);
    chk_out("fetch258_both", 32'h0, 1, 1, 1, 4'd5);

    step(0, 1, 0, 32'd4, 0, 0, 0);
    chk_out("fetch4_again", 32'hAC0C0004, 1, 0, 0, 4'd6);
    // Stall holds outputs; the load at 8 still lands.
    step(0, 1, 1, 32'd8, 1, 32'd8, 32'h12345678);
    chk_out("stall1", 32'hAC0C0004, 1, 0, 0, 4'd6);
    step(0, 1, 1, 32'd8, 0, 0, 0);
    chk_out("stall2", 32'hAC0C0004, 1, 0, 0, 4'd6);
    step(0, 1, 1, 32'd8, 0, 0, 0);
    chk_out("stall3", 32'hAC0C0004, 1, 0, 0, 4'd6);
    step(0, 1, 0, 32'd8, 0, 0, 0);
    chk_out("fetch8_loaded_in_stall", 32'h12345678, 1, 0, 0, 4'd7);

    step(0, 0, 0, 0, 1, 32'd10, 32'hDEADBEEF);
    chk_out("load_mis_dropped", 32'h0, 0, 0, 0, 4'd7);
    step(0, 1, 0, 32'd8, 0, 0, 0);
    chk_out("fetch8_unchanged", 32'h12345678, 1, 0, 0, 4'd8);
    step(0, 0, 0, 0, 1, 32'd256, 32'hFFFF0000);
    chk_out("load_oor_dropped", 32'h0, 0, 0, 0, 4'd8);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    chk_out("fetch0_unaliased", 32'h01098020, 1, 0, 0, 4'd9);

    step(0, 1, 0, 32'd16, 1, 32'd16, 32'h8C0D0004);
    chk_out("write_first16", 32'h8C0D0004, 1, 0, 0, 4'd10);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'd16, 0, 0, 0);
    chk_out("count15", 32'h8C0D0004, 1, 0, 0, 4'd15);
    step(0, 1, 0, 32'd6, 0, 0, 0);
    chk_out("count_wrap", 32'h0, 1, 1, 0, 4'd0);

    step(0, 1, 0, 32'd4, 0, 0, 0);
    chk_out("pre_reset", 32'hAC0C0004, 1, 0, 0, 4'd1);
    step(1, 1, 0, 32'd4, 1, 32'd0, 32'hFFFFFFFF);
    chk_out("mid_reset", 32'h0, 0, 0, 0, 4'd0);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    chk_out("post_reset0", 32'h01098020, 1, 0, 0, 4'd1);
    step(0, 1, 0, 32'd16, 0, 0, 0);
    chk_out("post_reset16", 32'h8C0D0004, 1, 0, 0, 4'd2);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("idle", 32'h0, 0, 0, 0, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
